fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one FIFO write port among N_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module fifo_wr_arbiter #(
   parameter int N_REQ      = 4,
   parameter int FIFO_WIDTH = 16,
   parameter int BURST_MAX  = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req,
   input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            gnt,
   output logic [FIFO_WIDTH-1:0]       fifo_data_in,
   output logic                        fifo_wr_en,
   input  logic                        fifo_full,
   input  logic                        fifo_almostfull,
   input  logic                        fifo_overflow,
   output logic                        arb_err,
   output logic [$clog2(N_REQ)-1:0]    owner
`ifdef FIFO_WR_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]         stat_cnt,
   output logic [15:0]                 stall_cnt
`endif
);

   localparam int PW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, BURST, STALL} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] ptr, win, win_inc;
   logic [3:0]    burst_cnt, cnt_nxt;
   logic          any_req, issue_ok, found, any_gnt;

   assign any_req = |req;
   // Never let a second write chase the one already headed for the last slot.
   assign issue_ok = !fifo_full && !(fifo_almostfull && fifo_wr_en);
   assign any_gnt = |gnt;

   always_comb begin : scan
      int j;
      j = 0;
      found = 1'b0;
      win = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         if (!found && req[j]) begin
            found = 1'b1;
            win = PW'(j);
         end
      end
   end

   assign win_inc = (int'(win) == N_REQ - 1) ? '0 : win + PW'(1);

   always_comb begin
      cnt_nxt = 4'd1;
      if (win == owner && state != IDLE) cnt_nxt = burst_cnt + 4'd1;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = IDLE;
      if (any_gnt)      state_nxt = BURST;
      else if (any_req) state_nxt = STALL;
   end

   // Output logic
   always_comb begin
      gnt = '0;
      if (!rst && issue_ok && found) gnt[win] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fifo_wr_en   <= 1'b0;
         fifo_data_in <= '0;
         arb_err      <= 1'b0;
         owner        <= '0;
         ptr          <= '0;
         burst_cnt    <= '0;
      end else begin
         fifo_wr_en <= any_gnt;
         if (fifo_overflow) arb_err <= 1'b1;
         if (any_gnt) begin
            fifo_data_in <= req_data[int'(win)*FIFO_WIDTH +: FIFO_WIDTH];
            owner        <= win;
            if (cnt_nxt < 4'(BURST_MAX)) begin
               ptr       <= win;
               burst_cnt <= cnt_nxt;
            end else begin
               ptr       <= win_inc;
               burst_cnt <= '0;
            end
         end
      end
   end

`ifdef FIFO_WR_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (gnt[i] && stat_cnt[i*16 +: 16] != 16'hFFFF)
               stat_cnt[i*16 +: 16] <= stat_cnt[i*16 +: 16] + 16'd1;
         if (state == STALL && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural model + depth-8 FIFO model, directed and random stimulus.
// Works with or without FIFO_WR_ARB_STATS_EN defined.
module tb_fifo_wr_arbiter;

   localparam int N = 4;
   localparam int W = 16;
   localparam int BMAX = 2;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req = '0;
   logic [N*W-1:0] req_data = '0;
   logic [N-1:0]  gnt;
   logic [W-1:0]  fifo_data_in;
   logic          fifo_wr_en;
   logic          fifo_full, fifo_almostfull, fifo_overflow;
   logic          arb_err;
   logic [1:0]    owner;
   logic          rd = 1'b0;
   logic          ovf_force = 1'b0;
   logic          ovf_reg = 1'b0;
   int            fcount = 0;
`ifdef FIFO_WR_ARB_STATS_EN
   logic [N*16-1:0] stat_cnt;
   logic [15:0]     stall_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign fifo_full = (fcount == DEPTH);
   assign fifo_almostfull = (fcount == DEPTH - 1);
   assign fifo_overflow = ovf_force | ovf_reg;

   fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .BURST_MAX(BMAX)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
      .fifo_data_in(fifo_data_in), .fifo_wr_en(fifo_wr_en),
      .fifo_full(fifo_full), .fifo_almostfull(fifo_almostfull),
      .fifo_overflow(fifo_overflow), .arb_err(arb_err), .owner(owner)
`ifdef FIFO_WR_ARB_STATS_EN
      , .stat_cnt(stat_cnt), .stall_cnt(stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: current and next-cycle values
   int m_ptr = 0, m_cnt = 0, m_owner = 0;
   bit m_busy = 0, m_wr = 0, m_err = 0, m_stalled = 0;
   logic [W-1:0] m_data = '0;
   int m_stat[N] = '{default: 0};
   int m_stall = 0;
   int n_ptr = 0, n_cnt = 0, n_owner = 0, n_fcount = 0;
   bit n_busy = 0, n_wr = 0, n_err = 0, n_stalled = 0, n_ovf = 0;
   logic [W-1:0] n_data = '0;
   int n_stat[N] = '{default: 0};
   int n_stall = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ptr = n_ptr; m_cnt = n_cnt; m_owner = n_owner; m_busy = n_busy;
         m_wr = n_wr; m_err = n_err; m_data = n_data; m_stalled = n_stalled;
         m_stat = n_stat; m_stall = n_stall;
         fcount = n_fcount; ovf_reg = n_ovf;
         @(negedge clk);
         #1;
         begin : cmp
            bit issue;
            int w, nc, j;
            logic [N-1:0] eg;
            logic [63:0] packed_stat;
            issue = (fcount != DEPTH) && !((fcount == DEPTH - 1) && m_wr);
            w = -1;
            eg = '0;
            if (!rst && issue)
               for (int k = 0; k < N; k++) begin
                  j = (m_ptr + k) % N;
                  if (w < 0 && req[j]) w = j;
               end
            if (w >= 0) eg[w] = 1'b1;
            check("gnt", 64'(gnt), 64'(eg));
            check("wr_en", 64'(fifo_wr_en), 64'(m_wr));
            check("data", 64'(fifo_data_in), 64'(m_data));
            check("owner", 64'(owner), 64'(m_owner));
            check("arb_err", 64'(arb_err), 64'(m_err));
            packed_stat = '0;
            for (int i = 0; i < N; i++) packed_stat[i*16 +: 16] = 16'(m_stat[i]);
`ifdef FIFO_WR_ARB_STATS_EN
            check("stat_cnt", 64'(stat_cnt), packed_stat);
            check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
            if (rst) begin
               n_ptr = 0; n_cnt = 0; n_owner = 0; n_busy = 0; n_wr = 0;
               n_err = 0; n_data = '0; n_stalled = 0; n_stall = 0;
               n_stat = '{default: 0};
               n_fcount = 0; n_ovf = 0;
            end else begin
               n_ptr = m_ptr; n_cnt = m_cnt; n_owner = m_owner; n_data = m_data;
               n_stat = m_stat;
               n_err = m_err || fifo_overflow;
               n_wr = (w >= 0);
               if (w >= 0) begin
                  n_data = req_data[w*W +: W];
                  nc = (w == m_owner && m_busy) ? m_cnt + 1 : 1;
                  if (nc < BMAX) begin
                     n_ptr = w; n_cnt = nc;
                  end else begin
                     n_ptr = (w + 1) % N; n_cnt = 0;
                  end
                  n_owner = w;
                  if (m_stat[w] < 65535) n_stat[w] = m_stat[w] + 1;
               end
               n_stall = (m_stalled && m_stall < 65535) ? m_stall + 1 : m_stall;
               n_busy = (req != 0);
               n_stalled = (req != 0) && (w < 0);
               n_fcount = fcount + ((fifo_wr_en && fcount < DEPTH) ? 1 : 0)
                        - ((rd && fcount > 0) ? 1 : 0);
               n_ovf = fifo_wr_en && (fcount == DEPTH);
            end
         end
      end
   end

   task automatic cyc(input logic [N-1:0] r, input logic rdv, input logic rs, input logic of);
      @(negedge clk);
      req = r;
      rd = rdv;
      rst = rs;
      ovf_force = of;
      req_data = {$urandom, $urandom};
      #2;
   endtask

   function automatic int idx(input logic [N-1:0] g);
      idx = -1;
      for (int i = 0; i < N; i++) if (g[i]) idx = i;
   endfunction

   initial begin : drive
      int exp_seq[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
      int writes, grants;
      bit blocked;

      // Reset with all requesting
      for (int i = 0; i < 2; i++) begin
         cyc(4'b1111, 1'b0, 1'b1, 1'b0);
         check("rst_gnt", 64'(gnt), 64'd0);
         check("rst_wr_en", 64'(fifo_wr_en), 64'd0);
         check("rst_owner", 64'(owner), 64'd0);
         check("rst_err", 64'(arb_err), 64'd0);
      end

      // Round-robin with bursts of two
      cyc(4'b0000, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc(4'b1111, 1'b1, 1'b0, 1'b0);
         check($sformatf("rr_seq%0d", i), 64'(idx(gnt)), 64'(exp_seq[i]));
      end
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);
      check("rr_last_wr", 64'(fifo_wr_en), 64'd1);
      check("rr_owner", 64'(owner), 64'd0);
`ifdef FIFO_WR_ARB_STATS_EN
      check("rr_stats", 64'(stat_cnt), {16'd2, 16'd2, 16'd2, 16'd3});
`endif

      // Fill to full with requester 2
      cyc(4'b0000, 1'b0, 1'b1, 1'b0);
      writes = 0;
      blocked = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(4'b0100, 1'b0, 1'b0, 1'b0);
         writes += int'(fifo_wr_en);
         if (fifo_almostfull && fifo_wr_en && gnt == 0) blocked = 1;
      end
      check("fill_writes", 64'(writes), 64'd8);
      check("fill_block", 64'(blocked), 64'd1);
      check("fill_count", 64'(fcount), 64'(DEPTH));
      check("fill_err", 64'(arb_err), 64'd0);

      // One read releases exactly one grant
      cyc(4'b0100, 1'b1, 1'b0, 1'b0);
      grants = int'(gnt != 0);
      for (int i = 0; i < 6; i++) begin
         cyc(4'b0100, 1'b0, 1'b0, 1'b0);
         grants += int'(gnt != 0);
         if (gnt != 0) check("rel_gnt", 64'(gnt), 64'b0100);
      end
      check("rel_grants", 64'(grants), 64'd1);
      check("rel_full", 64'(fifo_full), 64'd1);

      // Owner drops mid-burst
      cyc(4'b0000, 1'b1, 1'b1, 1'b0);
      cyc(4'b0011, 1'b1, 1'b0, 1'b0);
      check("drop_g0", 64'(gnt), 64'b0001);
      cyc(4'b0010, 1'b1, 1'b0, 1'b0);
      check("drop_g1", 64'(gnt), 64'b0010);
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);
      check("drop_owner", 64'(owner), 64'd1);

      // Sticky error
      cyc(4'b0000, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(4'b0000, 1'b1, 1'b0, 1'b0);
         check("err_sticky", 64'(arb_err), 64'd1);
      end
      cyc(4'b0000, 1'b1, 1'b1, 1'b0);
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);
      check("err_clear", 64'(arb_err), 64'd0);

      // Reset mid-burst
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      cyc(4'b1111, 1'b1, 1'b1, 1'b0);
      check("rstmid_gnt", 64'(gnt), 64'd0);
      cyc(4'b1111, 1'b1, 1'b0, 1'b0);
      check("rstmid_wr", 64'(fifo_wr_en), 64'd0);
      check("rstmid_owner", 64'(owner), 64'd0);
      check("rstmid_gnt0", 64'(gnt), 64'b0001);

      // Random traffic
      for (int i = 0; i < 3000; i++)
         cyc(4'($urandom), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 99) == 0), ($urandom_range(0, 499) == 0));
      cyc(4'b0000, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
